multi_edge_detector: RTL and testbench

- Parametrised, multi-channel successor to the single-level rising-edge tick generator.
- Each channel passes through a synchroniser chain, an optional debounce filter, and a per-channel edge-mode selector (off / rise / fall / both).
- Each channel produces a one-cycle tick, a sticky pending flag, and an overflow flag. An OR-reduced irq_o feeds the interrupt/status logic.
- Used for buttons, switches and external async strobes.

---
 rtl/edge_pkg.sv | 15 +
 rtl/edge_chan.sv | 114 +++++++++++
 rtl/multi_edge_detector.sv | 43 ++++
 tb/tb_multi_edge_detector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings
// and the debounce counter sizing helper.
package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter only has to reach d-1, so $clog2(d) bits, never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchroniser, optional debounce, edge select,
// registered tick plus sticky pending/overflow flags.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_i,
    input  logic [1:0] mode_i,
    input  logic       clear_i,
    output logic       level_o,
    output logic       tick_o,
    output logic       pending_o,
    output logic       overflow_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic sync_out;
    logic stable;
    logic prev_q, prev_d;
    logic tick_q, tick_d;
    logic pending_q, pending_d;
    logic overflow_q, overflow_d;
    logic rise, fall, hit;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], level_i};
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic stable_q, stable_d;

            // Any sample matching the accepted level restarts the count,
            // so only an unbroken run of D differing samples is accepted.
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (sync_out != stable_q) begin
                    if (cnt_q == CNT_LAST) stable_d = sync_out;
                    else                   cnt_d    = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable = stable_q;
        end else begin : g_bypass
            assign stable = sync_out;
        end
    endgenerate

    always_comb begin
        rise = stable & ~prev_q;
        fall = ~stable & prev_q;
        case (mode_i)
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase

        prev_d    = stable;
        tick_d    = hit;
        pending_d = hit | (pending_q & ~clear_i);

        // A clear that coincides with a new hit leaves overflow untouched.
        overflow_d = overflow_q;
        if (clear_i) begin
            if (!hit) overflow_d = 1'b0;
        end else if (hit && pending_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= 1'b0;
            tick_q     <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            tick_q     <= tick_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign level_o    = stable;
    assign tick_o     = tick_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N independent edge-detector channels with an OR-reduced interrupt of the
// per-channel pending flags.
module multi_edge_detector
    import edge_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level_i,
    input  logic [2*N-1:0] mode_i,
    input  logic [N-1:0]   clear_i,
    output logic [N-1:0]   level_o,
    output logic [N-1:0]   tick_o,
    output logic [N-1:0]   pending_o,
    output logic [N-1:0]   overflow_o,
    output logic           irq_o
);

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            edge_chan #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .level_i   (level_i[i]),
                .mode_i    (mode_i[2*i+1:2*i]),
                .clear_i   (clear_i[i]),
                .level_o   (level_o[i]),
                .tick_o    (tick_o[i]),
                .pending_o (pending_o[i]),
                .overflow_o(overflow_o[i])
            );
        end
    endgenerate

    assign irq_o = |pending_o;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed and randomized checks of multi_edge_detector against a
// history-based reference model of the channel behaviour.
module tb_multi_edge_detector;

    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   level_i;
    logic [2*N-1:0] mode_i;
    logic [N-1:0]   clear_i;
    logic [N-1:0]   level_o;
    logic [N-1:0]   tick_o;
    logic [N-1:0]   pending_o;
    logic [N-1:0]   overflow_o;
    logic           irq_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: raw input history (newest first) plus accepted flags.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_stable, m_prev, m_tick, m_pend, m_ovf;

    multi_edge_detector #(
        .N              (N),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .level_i   (level_i),
        .mode_i    (mode_i),
        .clear_i   (clear_i),
        .level_o   (level_o),
        .tick_o    (tick_o),
        .pending_o (pending_o),
        .overflow_o(overflow_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (S + D) hist.push_back('0);
        m_stable = '0;
        m_prev   = '0;
        m_tick   = '0;
        m_pend   = '0;
        m_ovf    = '0;
    endtask

    // Level seen at the synchroniser output at edge j is the raw level from
    // edge j-S; a change is accepted once the last D such samples all differ.
    task automatic model_step();
        logic os, op, hit, clr, accept;
        logic [1:0] md;
        for (int c = 0; c < N; c++) begin
            os  = m_stable[c];
            op  = m_prev[c];
            md  = mode_i[2*c +: 2];
            clr = clear_i[c];
            hit = ((md == 2'b01) && os && !op) ||
                  ((md == 2'b10) && !os && op) ||
                  ((md == 2'b11) && (os != op));
            if (clr) begin
                if (!hit) m_ovf[c] = 1'b0;
            end else if (hit && m_pend[c]) begin
                m_ovf[c] = 1'b1;
            end
            m_pend[c] = hit || (m_pend[c] && !clr);
            m_tick[c] = hit;
            m_prev[c] = os;
            if (D > 0) begin
                accept = 1'b1;
                for (int k = 0; k < D; k++)
                    if (hist[S-1+k][c] == os) accept = 1'b0;
                if (accept) m_stable[c] = !os;
            end
        end
        hist.push_front(level_i);
        void'(hist.pop_back());
        if (D == 0) m_stable = hist[S-1];
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_level"},    32'(level_o),    32'(m_stable));
        check({tag, "_tick"},     32'(tick_o),     32'(m_tick));
        check({tag, "_pending"},  32'(pending_o),  32'(m_pend));
        check({tag, "_overflow"}, 32'(overflow_o), 32'(m_ovf));
        check({tag, "_irq"},      32'(irq_o),      32'(|m_pend));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        int ticks, lvl_hi, t_first, t_second;

        reset   = 1'b0;
        level_i = '0;
        mode_i  = '0;
        clear_i = '0;
        model_reset();
        #1;
        check("rst_level",    32'(level_o),    0);
        check("rst_tick",     32'(tick_o),     0);
        check("rst_pending",  32'(pending_o),  0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_irq",      32'(irq_o),      0);
        @(negedge clk);
        @(negedge clk);

        // Basic rise latency on ch0
        reset      = 1'b1;
        mode_i     = 8'b00_00_00_01;
        level_i[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step("t1");
            if (e == 5) check("t1_level_e5", 32'(level_o[0]), 0);
            if (e == 6) check("t1_level_e6", 32'(level_o[0]), 1);
            if (e == 6) check("t1_tick_e6",  32'(tick_o[0]),  0);
            if (e == 7) check("t1_tick_e7",  32'(tick_o[0]),  1);
            if (e == 8) begin
                check("t1_tick_e8",   32'(tick_o[0]),    0);
                check("t1_pending",   32'(pending_o[0]), 1);
                check("t1_irq",       32'(irq_o),        1);
                check("t1_others",    32'({level_o[3:1], tick_o[3:1], pending_o[3:1]}), 0);
            end
        end

        // Glitch rejection and minimum accepted pulse on ch1
        mode_i[3:2] = 2'b11;
        level_i[1]  = 1'b1;
        repeat (3) step("t2g");
        level_i[1] = 1'b0;
        ticks = 0; lvl_hi = 0;
        for (int i = 0; i < 12; i++) begin
            step("t2g");
            ticks  += int'(tick_o[1]);
            lvl_hi += int'(level_o[1]);
        end
        check("t2_glitch_ticks", 32'(ticks),  0);
        check("t2_glitch_level", 32'(lvl_hi), 0);
        level_i[1] = 1'b1;
        repeat (4) step("t2p");
        level_i[1] = 1'b0;
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            step("t2p");
            ticks += int'(tick_o[1]);
        end
        check("t2_pulse_ticks", 32'(ticks), 2);

        // Both-edge mode without clear: second tick overflows on ch2
        mode_i[5:4] = 2'b11;
        level_i[2]  = 1'b1;
        ticks = 0; t_first = -1; t_second = -1;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) level_i[2] = 1'b0;
            step("t3");
            if (tick_o[2]) begin
                ticks++;
                if (t_first < 0) t_first = i; else t_second = i;
            end
        end
        check("t3_ticks",    32'(ticks), 2);
        check("t3_spacing",  32'(t_second - t_first), 10);
        check("t3_pending",  32'(pending_o[2]),  1);
        check("t3_overflow", 32'(overflow_o[2]), 1);

        // Clear coinciding with a new tick on ch3: set wins, no overflow
        mode_i[7:6] = 2'b01;
        level_i[3]  = 1'b1;
        repeat (10) step("t4");
        level_i[3] = 1'b0;
        repeat (10) step("t4");
        level_i[3] = 1'b1;
        repeat (6) step("t4");
        clear_i[3] = 1'b1;
        step("t4c");
        check("t4_tick",      32'(tick_o[3]),     1);
        check("t4_pending",   32'(pending_o[3]),  1);
        check("t4_overflow",  32'(overflow_o[3]), 0);
        step("t4c");
        check("t4_clr_pend",  32'(pending_o[3]),  0);
        check("t4_clr_ovf",   32'(overflow_o[3]), 0);
        clear_i[3] = 1'b0;

        // Mode off on ch0: level tracks, no ticks or pending
        mode_i[1:0] = 2'b00;
        clear_i[0]  = 1'b1;
        step("t5");
        clear_i[0] = 1'b0;
        ticks = 0;
        for (int v = 0; v < 2; v++) begin
            level_i[0] = v[0];
            for (int e = 1; e <= 8; e++) begin
                step("t5");
                ticks += int'(tick_o[0]);
                if (e == 5) check("t5_level_e5", 32'(level_o[0]), 32'(!v[0]));
                if (e == 6) check("t5_level_e6", 32'(level_o[0]), 32'(v[0]));
            end
        end
        check("t5_ticks",   32'(ticks),        0);
        check("t5_pending", 32'(pending_o[0]), 0);

        // Reset mid-debounce with ch1 held high
        mode_i[3:2] = 2'b01;
        level_i[1]  = 1'b1;
        repeat (3) step("t6");
        #2 reset = 1'b0;
        #1;
        check("t6_rst_level",    32'(level_o),    0);
        check("t6_rst_tick",     32'(tick_o),     0);
        check("t6_rst_pending",  32'(pending_o),  0);
        check("t6_rst_overflow", 32'(overflow_o), 0);
        check("t6_rst_irq",      32'(irq_o),      0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step("t6");
            if (e == 6) check("t6_tick_e6", 32'(tick_o[1]), 0);
            if (e == 7) check("t6_tick_e7", 32'(tick_o[1]), 1);
            if (e == 8) check("t6_tick_e8", 32'(tick_o[1]), 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) level_i[c] = !level_i[c];
                clear_i[c] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 49) == 0) mode_i = 8'($urandom);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
